arp_req_arbiter: RTL

Shares the single ARP cache lookup port among NUM_REQ per-channel frame buffers that each issue one IP-to-MAC query per buffered frame. It latches each requester's query, grants one requester at a time in round-robin order, forwards the query to the ARP cache, and routes the MAC result or a delete verdict back to the granted requester only. It also applies a response timeout so that a silent cache cannot stall a channel.

---
 rtl/arp_req_arbiter_pkg.sv | 18 +
 rtl/arp_req_arbiter_rr_arbiter.sv | 49 ++++
 rtl/arp_req_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/arp_req_arbiter_pkg.sv
// Shared types and constants for the ARP lookup-port arbiter.
package arp_req_arbiter_pkg;

   localparam int IP_W   = 32;
   localparam int PORT_W = 4;
   localparam int MAC_W  = 48;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   typedef enum logic {
      VD_HIT,
      VD_DEL
   } verdict_t;

endpackage

// File: rtl/arp_req_arbiter_rr_arbiter.sv
// Round-robin picker: combinational grant from a registered
// priority pointer that moves past each granted requester.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk_net,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               upd,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   localparam int SW = IDX_W + 1;

   logic [IDX_W-1:0] ptr;
   logic [SW-1:0]    s;
   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      s         = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         s = {1'b0, ptr} + SW'(k);
         if (s >= SW'(NUM_REQ))
            s = s - SW'(NUM_REQ);
         cand = s[IDX_W-1:0];
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk_net or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (upd)
         ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ?
                '0 : grant_idx + IDX_W'(1);
   end

endmodule

// File: rtl/arp_req_arbiter.sv
// Shares one ARP cache lookup port among NUM_REQ channels,
// with per-requester holding registers and a response timeout.
module arp_req_arbiter
   import arp_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk_net,
   input  logic                      rst,
   input  logic [32*NUM_REQ-1:0]     req_ip,
   input  logic [4*NUM_REQ-1:0]      req_port,
   input  logic [NUM_REQ-1:0]        req_en,
   output logic [MAC_W-1:0]          resp_mac,
   output logic [NUM_REQ-1:0]        resp_mac_en,
   output logic [NUM_REQ-1:0]        resp_del_en,
   output logic [IP_W-1:0]           arp_ip_out,
   output logic [PORT_W-1:0]         arp_port_out,
   output logic                      arp_query_en,
   input  logic [MAC_W-1:0]          arp_mac_in,
   input  logic                      arp_hit_en,
   input  logic                      arp_miss_en
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [1:0]         state;
   logic [NUM_REQ-1:0] pending;
   logic [IP_W-1:0]    hold_ip   [NUM_REQ];
   logic [PORT_W-1:0]  hold_port [NUM_REQ];
   logic [IDX_W-1:0]   g;
   logic [CNT_W-1:0]   cnt;

   logic [NUM_REQ-1:0] gnt_oh;
   logic [IDX_W-1:0]   gnt_idx;
   logic               do_grant;
   logic [NUM_REQ-1:0] clr;
   logic [NUM_REQ-1:0] g_oh;
   logic               vd_go;
   verdict_t           vd;

   assign do_grant = (state == ST_IDLE) && (|pending);
   assign clr      = do_grant ? gnt_oh : '0;
   assign g_oh     = NUM_REQ'(1) << g;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .clk_net   (clk_net),
      .rst       (rst),
      .req       (pending),
      .upd       (do_grant),
      .grant     (gnt_oh),
      .grant_idx (gnt_idx)
   );

   // Miss wins over a simultaneous hit; timeout only without a strobe.
   always_comb begin
      vd_go = 1'b0;
      vd    = VD_DEL;
      if (state == ST_WAIT) begin
         if (arp_miss_en) begin
            vd_go = 1'b1;
         end else if (arp_hit_en) begin
            vd_go = 1'b1;
            vd    = VD_HIT;
         end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            vd_go = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_net or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         pending      <= '0;
         g            <= '0;
         cnt          <= '0;
         resp_mac     <= '0;
         resp_mac_en  <= '0;
         resp_del_en  <= '0;
         arp_ip_out   <= '0;
         arp_port_out <= '0;
         arp_query_en <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            hold_ip[i]   <= '0;
            hold_port[i] <= '0;
         end
      end else begin
         arp_query_en <= 1'b0;
         resp_mac_en  <= '0;
         resp_del_en  <= '0;
         // A new strobe in the grant cycle re-arms the slot.
         pending <= (pending & ~clr) | req_en;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_en[i] && (!pending[i] || clr[i])) begin
               hold_ip[i]   <= req_ip[32*i +: 32];
               hold_port[i] <= req_port[4*i +: 4];
            end
         end
         case (state)
            ST_IDLE: begin
               if (do_grant) begin
                  g            <= gnt_idx;
                  arp_ip_out   <= hold_ip[gnt_idx];
                  arp_port_out <= hold_port[gnt_idx];
                  arp_query_en <= 1'b1;
                  state        <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt   <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               cnt <= cnt + CNT_W'(1);
               if (vd_go) begin
                  state <= ST_RESP;
                  if (vd == VD_HIT) begin
                     resp_mac    <= arp_mac_in;
                     resp_mac_en <= g_oh;
                  end else begin
                     resp_del_en <= g_oh;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
